sector_write_scheduler: RTL and testbench
=========================================

Name: sector_write_scheduler

Overview:
Sequences sector writes out of the 2x512-byte ping-pong sector write buffer filled by the digitizer-buffer pump.
- Tracks which half holds a complete sector and issues one write command per sector, in strict half order, to the storage writer.
- Assigns ascending LBAs and retries failed writes.
- Releases each half back to the pump by toggling its BUFWAITING bit.

Parameters:
START_LBA, 32'd0, LBA of first sector written after ENA rises.
MAX_SECTORS, 32'hFFFF_FFFF, sector count after which scheduler halts (0 = never halt).
RETRY_MAX, 2, retries per sector after first failed attempt (3 attempts total at default).
TIMEOUT_CYCLES, 24'd1_000_000, WAIT_DONE watchdog limit (used only with SCHED_TIMEOUT_EN).

Ports:
CLK  input  1  system clock; all logic on posedge.
RST  input  1  reset, asynchronous, active-low.
ENA  input  1  run enable; low = synchronous return to IDLE, pending flags cleared, counters kept.
BUFREADY_PUMP  input  2  bit i rising = half i (0: bytes 0-511, 1: 512-1023) now holds a full sector.
BUFWAITING  output  2  bit i toggles once per release of half i.
WR_REQ  output  1  write command valid; held until WR_ACK.
WR_HALF  output  1  buffer half to write; stable while WR_REQ high.
WR_LBA  output  32  target LBA; stable while WR_REQ high.
WR_ACK  input  1  writer accepted command (one-cycle pulse).
WR_DONE  input  1  writer finished (one-cycle pulse).
WR_ERR  input  1  qualifies WR_DONE: 1 = failed write.
SECTORS_WRITTEN  output  32  count of successfully written sectors.
OVERRUN  output  1  sticky: half refilled before release.
FAULT  output  1  sticky: sector failed RETRY_MAX+1 attempts.
BUSY  output  1  high in any state except IDLE, WAIT_BUF and HALT.

Behaviour:
Reset values (RST low):
- All outputs 0.
- State IDLE.
- pending = 2'b00.
- nextHalf = 0.
- lba = START_LBA.
- retry count = 0.

Pending tracking:
- BUFREADY_PUMP registered once; rising edge on bit i sets pending[i].
- If pending[i] is already set at that edge: OVERRUN is set and the event is dropped.
- Set and clear of pending[i] in the same cycle: set wins.

FSM:
- IDLE: ENA=1 -> WAIT_BUF.
- WAIT_BUF: pending[nextHalf]=1 -> REQ. The other half's pending flag is never serviced out of order.
- REQ: WR_REQ=1, WR_HALF=nextHalf, WR_LBA=lba. WR_ACK -> WAIT_DONE, WR_REQ drops the next cycle.
- WAIT_DONE on WR_DONE:
  - WR_ERR=0 -> RELEASE.
  - WR_ERR=1 and retries<RETRY_MAX -> retries+1, back to REQ with the same LBA and half.
  - Otherwise set FAULT -> RELEASE. The sector is skipped; lba still advances, SECTORS_WRITTEN does not.
- RELEASE (one cycle):
  - Clear pending[nextHalf] and toggle BUFWAITING[nextHalf].
  - nextHalf flips.
  - lba+1, wrapping 32'hFFFF_FFFF -> 0.
  - SECTORS_WRITTEN+1 on success.
  - retries=0.
  - If MAX_SECTORS!=0 and sectors attempted == MAX_SECTORS -> HALT, else WAIT_BUF.
- HALT: stays until ENA low.

ENA low (any state) next cycle:
- State IDLE, WR_REQ=0, pending cleared, nextHalf=0, retries=0.
- lba and SECTORS_WRITTEN hold, so re-enable continues the LBA stream.
- An outstanding WR_DONE arriving later is ignored.
- Writer handshake abort is the writer's responsibility.

Other rules:
- WR_ACK and WR_DONE are ignored outside their states.
- WR_ACK and WR_DONE in the same cycle while in REQ: treated as ACK followed by DONE, going straight to RELEASE/retry.
- Latency: pending set -> WR_REQ is 2 cycles (WAIT_BUF, REQ). WR_DONE -> BUFWAITING toggle is 2 cycles.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined: 24-bit counter runs in WAIT_DONE, cleared on entry. Reaching TIMEOUT_CYCLES is treated exactly as WR_DONE with WR_ERR=1, following the retry/FAULT path.
- Not defined: no counter; WAIT_DONE waits indefinitely. TIMEOUT_CYCLES is unused.

Decomposition:
- Shared defines file: state encodings (IDLE, WAIT_BUF, REQ, WAIT_DONE, RELEASE, HALT; one-hot, safe), SECTOR_BYTES=512, HALF_LO/HALF_HI indices.
- One sub-module, sector_pending_tracker: BUFREADY_PUMP edge detect, pending[1:0], clear interface, OVERRUN generation.

Test Plan:
1. Reset, ENA=1, rise BUFREADY_PUMP[0] -> WR_REQ 2 cycles later, WR_HALF=0, WR_LBA=0. DONE with ERR=0 -> BUFWAITING=2'b01, SECTORS_WRITTEN=1.
2. Four alternating half fills with START_LBA=100 -> LBAs 100..103 on halves 0,1,0,1. BUFWAITING ends at 2'b00 after two toggles per bit.
3. WR_ERR=1 on three attempts (RETRY_MAX=2) -> three REQs at the same LBA, FAULT=1, half released, next sector gets LBA+1, SECTORS_WRITTEN unchanged.
4. Second rise on BUFREADY_PUMP[0] while pending[0] is set -> OVERRUN=1, exactly one write issued for half 0.
5. MAX_SECTORS=2 -> after two releases state HALT, BUSY=0, new fills ignored until ENA toggles low/high. LBA continues at 2.
6. With SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=50, withhold WR_DONE -> re-REQ at cycle 50 of WAIT_DONE. Without the macro, no re-REQ after 10000 cycles. Assert RST mid-WAIT_DONE -> all outputs 0 immediately.

Source files
------------

// File: rtl/sector_write_scheduler_pkg.sv
// Shared definitions for the sector write scheduler.
//   state_e      : one-hot FSM encodings (illegal encodings recover to IDLE)
//   SECTOR_BYTES : bytes per ping-pong half
//   HALF_LO/HI   : half indices (0 = bytes 0-511, 1 = bytes 512-1023)
//   is_busy()    : states in which the scheduler reports BUSY
package sector_write_scheduler_pkg;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_WAIT_BUF  = 6'b000010,
        ST_REQ       = 6'b000100,
        ST_WAIT_DONE = 6'b001000,
        ST_RELEASE   = 6'b010000,
        ST_HALT      = 6'b100000
    } state_e;

    localparam int SECTOR_BYTES = 512;
    localparam int HALF_LO      = 0;
    localparam int HALF_HI      = 1;

    function automatic logic is_busy(input state_e s);
        return (s == ST_REQ) || (s == ST_WAIT_DONE) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/sector_write_scheduler_pending.sv
// sector_pending_tracker: records which buffer half holds a full sector.
//   clk, rst_n      : clock, async active-low reset
//   ena             : low clears pending flags (OVERRUN is sticky and kept)
//   bufready_pump   : per-half "sector full" level from the pump; rising edge marks pending
//   clr_en, clr_idx : release of one half by the scheduler
//   pending         : per-half pending flags
//   overrun         : sticky; a half was refilled before it was released
module sector_pending_tracker
    import sector_write_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] bufready_pump,
    input  logic       clr_en,
    input  logic       clr_idx,
    output logic [1:0] pending,
    output logic       overrun
);

    logic [1:0] bufready_q;
    logic [1:0] pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic [1:0] rise, clr;

    always_comb begin
        rise          = bufready_pump & ~bufready_q;
        clr           = 2'b00;
        clr[HALF_LO]  = clr_en & (clr_idx == 1'b0);
        clr[HALF_HI]  = clr_en & (clr_idx == 1'b1);
        // A rise landing in the release cycle of the same half is a legal
        // refill: the set wins and it is not an overrun.
        pending_d     = (pending_q & ~clr) | rise;
        overrun_d     = overrun_q | (|(rise & pending_q & ~clr));
        if (!ena) begin
            pending_d = 2'b00;
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufready_q <= 2'b00;
            pending_q  <= 2'b00;
            overrun_q  <= 1'b0;
        end else begin
            bufready_q <= bufready_pump;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sector_write_scheduler.sv
// sector_write_scheduler: issues one write per full ping-pong half, in strict
// half order, with ascending LBAs, retries, and per-half release toggles.
//   CLK, RST        : clock, async active-low reset
//   ENA             : run enable; low returns to IDLE (lba / counters kept)
//   BUFREADY_PUMP   : per-half full indication from the pump
//   BUFWAITING      : per-half toggle on release
//   WR_REQ/HALF/LBA : write command to the storage writer, held until WR_ACK
//   WR_ACK/DONE/ERR : writer handshake
//   SECTORS_WRITTEN : successful sector count
//   OVERRUN, FAULT  : sticky error flags
//   BUSY            : command in flight (REQ, WAIT_DONE, RELEASE)
// Optional: define SCHED_TIMEOUT_EN to add a WAIT_DONE watchdog of
// TIMEOUT_CYCLES cycles that is treated as a failed write.
module sector_write_scheduler
    import sector_write_scheduler_pkg::*;
#(
    parameter logic [31:0] START_LBA      = 32'd0,
    parameter logic [31:0] MAX_SECTORS    = 32'hFFFF_FFFF,
    parameter int          RETRY_MAX      = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENA,
    input  logic [1:0]  BUFREADY_PUMP,
    output logic [1:0]  BUFWAITING,
    output logic        WR_REQ,
    output logic        WR_HALF,
    output logic [31:0] WR_LBA,
    input  logic        WR_ACK,
    input  logic        WR_DONE,
    input  logic        WR_ERR,
    output logic [31:0] SECTORS_WRITTEN,
    output logic        OVERRUN,
    output logic        FAULT,
    output logic        BUSY
);

    localparam logic [7:0] RETRY_MAX_C = 8'(RETRY_MAX);

    state_e      state_q, state_d;
    logic        next_half_q, next_half_d;
    logic [31:0] lba_q, lba_d;
    logic [7:0]  retry_q, retry_d;
    logic [31:0] attempted_q, attempted_d;
    logic [31:0] written_q, written_d;
    logic [1:0]  bufwaiting_q, bufwaiting_d;
    logic        wr_req_q, wr_req_d;
    logic        fault_q, fault_d;
    logic        failed_q, failed_d;   // current sector gave up after all attempts
    logic        busy_q, busy_d;
    logic        done_ev, done_err;
    logic [1:0]  pending;
`ifdef SCHED_TIMEOUT_EN
    logic [23:0] tmo_q, tmo_d;
`endif

    sector_pending_tracker u_pending (
        .clk           (CLK),
        .rst_n         (RST),
        .ena           (ENA),
        .bufready_pump (BUFREADY_PUMP),
        .clr_en        (state_q == ST_RELEASE),
        .clr_idx       (next_half_q),
        .pending       (pending),
        .overrun       (OVERRUN)
    );

    always_comb begin
        state_d      = state_q;
        next_half_d  = next_half_q;
        lba_d        = lba_q;
        retry_d      = retry_q;
        attempted_d  = attempted_q;
        written_d    = written_q;
        bufwaiting_d = bufwaiting_q;
        fault_d      = fault_q;
        failed_d     = failed_q;
        done_ev      = 1'b0;
        done_err     = 1'b0;

        case (state_q)
            ST_IDLE:     if (ENA) state_d = ST_WAIT_BUF;
            ST_WAIT_BUF: if (pending[next_half_q]) state_d = ST_REQ;
            ST_REQ: begin
                if (WR_ACK) begin
                    state_d = ST_WAIT_DONE;
                    // ACK and DONE together: handled as ACK then DONE
                    done_ev  = WR_DONE;
                    done_err = WR_ERR;
                end
            end
            ST_WAIT_DONE: begin
                done_ev  = WR_DONE;
                done_err = WR_ERR;
`ifdef SCHED_TIMEOUT_EN
                if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                    done_ev  = 1'b1;
                    done_err = WR_DONE ? WR_ERR : 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                bufwaiting_d[next_half_q] = ~bufwaiting_q[next_half_q];
                next_half_d = ~next_half_q;
                lba_d       = lba_q + 32'd1;   // wraps to 0 naturally
                if (!failed_q) written_d = written_q + 32'd1;
                retry_d     = 8'd0;
                failed_d    = 1'b0;
                attempted_d = attempted_q + 32'd1;
                if (MAX_SECTORS != 32'd0 && attempted_d == MAX_SECTORS)
                    state_d = ST_HALT;
                else
                    state_d = ST_WAIT_BUF;
            end
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_IDLE;
        endcase

        if (done_ev) begin
            if (!done_err) begin
                state_d = ST_RELEASE;
            end else if (retry_q < RETRY_MAX_C) begin
                retry_d = retry_q + 8'd1;
                state_d = ST_REQ;
            end else begin
                fault_d  = 1'b1;
                failed_d = 1'b1;
                state_d  = ST_RELEASE;
            end
        end

        // ENA low overrides everything; the session sector count restarts
        // so MAX_SECTORS applies afresh after re-enable.
        if (!ENA) begin
            state_d     = ST_IDLE;
            next_half_d = 1'b0;
            retry_d     = 8'd0;
            failed_d    = 1'b0;
            attempted_d = 32'd0;
        end

        wr_req_d = (state_d == ST_REQ);
        busy_d   = is_busy(state_d);
`ifdef SCHED_TIMEOUT_EN
        tmo_d = (state_q == ST_WAIT_DONE && state_d == ST_WAIT_DONE) ? tmo_q + 24'd1 : 24'd0;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            next_half_q  <= 1'b0;
            lba_q        <= START_LBA;
            retry_q      <= 8'd0;
            attempted_q  <= 32'd0;
            written_q    <= 32'd0;
            bufwaiting_q <= 2'b00;
            wr_req_q     <= 1'b0;
            fault_q      <= 1'b0;
            failed_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            tmo_q        <= 24'd0;
`endif
        end else begin
            state_q      <= state_d;
            next_half_q  <= next_half_d;
            lba_q        <= lba_d;
            retry_q      <= retry_d;
            attempted_q  <= attempted_d;
            written_q    <= written_d;
            bufwaiting_q <= bufwaiting_d;
            wr_req_q     <= wr_req_d;
            fault_q      <= fault_d;
            failed_q     <= failed_d;
            busy_q       <= busy_d;
`ifdef SCHED_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    // Command fields are qualified by WR_REQ so every output is 0 in reset
    // even when START_LBA is non-zero.
    assign WR_REQ          = wr_req_q;
    assign WR_HALF         = wr_req_q & next_half_q;
    assign WR_LBA          = wr_req_q ? lba_q : 32'd0;
    assign BUFWAITING      = bufwaiting_q;
    assign SECTORS_WRITTEN = written_q;
    assign FAULT           = fault_q;
    assign BUSY            = busy_q;

endmodule

// File: tb/tb_sector_write_scheduler.sv
module tb_sector_write_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ENA = 1'b0;
    logic [1:0]  BUFREADY_PUMP = 2'b00;
    logic [1:0]  BUFWAITING;
    logic        WR_REQ, WR_HALF;
    logic [31:0] WR_LBA;
    logic        WR_ACK = 1'b0, WR_DONE = 1'b0, WR_ERR = 1'b0;
    logic [31:0] SECTORS_WRITTEN;
    logic        OVERRUN, FAULT, BUSY;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [31:0] m_lba, m_written;
    logic [1:0]  m_bw;
    bit          m_fault;

    always #5 CLK = ~CLK;

    sector_write_scheduler #(
        .START_LBA(32'd100), .MAX_SECTORS(32'd6), .RETRY_MAX(2), .TIMEOUT_CYCLES(24'd50)
    ) dut (
        .CLK(CLK), .RST(RST), .ENA(ENA), .BUFREADY_PUMP(BUFREADY_PUMP),
        .BUFWAITING(BUFWAITING), .WR_REQ(WR_REQ), .WR_HALF(WR_HALF), .WR_LBA(WR_LBA),
        .WR_ACK(WR_ACK), .WR_DONE(WR_DONE), .WR_ERR(WR_ERR),
        .SECTORS_WRITTEN(SECTORS_WRITTEN), .OVERRUN(OVERRUN), .FAULT(FAULT), .BUSY(BUSY)
    );

    typedef struct {
        bit          half;
        int          fails;     // failed attempts before success; 3 = all attempts fail
        int          ack_dly;
        int          done_dly;  // 0 = DONE together with ACK
        logic [31:0] lba;
        logic [1:0]  bw;
        logic [31:0] wr;
        bit          fault;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic fill(input bit h);
        BUFREADY_PUMP[h] = 1'b1;
        step();
        BUFREADY_PUMP[h] = 1'b0;
    endtask

    task automatic ena_cycle();
        ENA = 1'b0; step(); step();
        ENA = 1'b1; step(); step();
    endtask

    // Model of one sector from the rules: LBA advances always, count only on success.
    task automatic model_sector(input bit h, input int fails);
        m_lba   = m_lba + 32'd1;
        if (fails < 3) m_written = m_written + 32'd1;
        if (fails >= 3) m_fault = 1'b1;
        m_bw[h] = ~m_bw[h];
    endtask

    // Acts as the storage writer for one sector, checking the command fields.
    task automatic serve(input string tag, input bit h, input logic [31:0] lba,
                         input int fails, input int ack_dly, input int done_dly,
                         input logic [1:0] bw_exp, input logic [31:0] wr_exp, input bit fault_exp);
        int  n;
        int  attempts;
        bit  err;
        logic [1:0] bw_pre;
        attempts = (fails >= 3) ? 3 : fails + 1;
        for (int a = 0; a < attempts; a++) begin
            n = 0;
            while (!WR_REQ && n < 200) begin step(); n++; end
            chk({tag, "_req"}, WR_REQ, 1);
            chk({tag, "_half"}, WR_HALF, h);
            chk({tag, "_lba"}, WR_LBA, lba);
            repeat (ack_dly) step();
            chk({tag, "_held"}, {WR_REQ, WR_HALF, WR_LBA[29:0]}, {1'b1, h, lba[29:0]});
            err = (a < fails);
            WR_ACK = 1'b1;
            if (done_dly == 0) begin WR_DONE = 1'b1; WR_ERR = err; end
            step();
            WR_ACK = 1'b0; WR_DONE = 1'b0; WR_ERR = 1'b0;
            if (done_dly != 0) begin
                chk({tag, "_drop"}, WR_REQ, 0);
                repeat (done_dly - 1) step();
                WR_DONE = 1'b1; WR_ERR = err;
                step();
                WR_DONE = 1'b0; WR_ERR = 1'b0;
            end
        end
        bw_pre = bw_exp;
        bw_pre[h] = ~bw_pre[h];
        chk({tag, "_bw_early"}, BUFWAITING, bw_pre);
        step();
        chk({tag, "_bw"}, BUFWAITING, bw_exp);
        chk({tag, "_written"}, SECTORS_WRITTEN, wr_exp);
        chk({tag, "_fault"}, FAULT, fault_exp);
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  h;
        int  r, f;

        vt[0] = '{1'b0, 0, 0, 2, 32'd100, 2'b01, 32'd1, 1'b0};
        vt[1] = '{1'b1, 0, 2, 0, 32'd101, 2'b11, 32'd2, 1'b0};
        vt[2] = '{1'b0, 1, 1, 1, 32'd102, 2'b10, 32'd3, 1'b0};
        vt[3] = '{1'b1, 3, 0, 3, 32'd103, 2'b00, 32'd3, 1'b1};
        vt[4] = '{1'b0, 0, 3, 0, 32'd104, 2'b01, 32'd4, 1'b1};
        vt[5] = '{1'b1, 2, 0, 1, 32'd105, 2'b11, 32'd5, 1'b1};

        // reset state
        #12;
        chk("rst_wr_lba", WR_LBA, 0);
        chk("rst_written", SECTORS_WRITTEN, 0);
        chk("rst_flags", {BUFWAITING, WR_REQ, WR_HALF, OVERRUN, FAULT, BUSY}, 0);
        step();
        RST = 1'b1; step();
        ENA = 1'b1; step(); step();

        // table: sectors 100..105, halting after the sixth
        for (int i = 0; i < 6; i++) begin
            fill(vt[i].half);
            chk("lat_early", WR_REQ, 0);
            step();
            chk("lat_req", WR_REQ, 1);
            serve($sformatf("vec%0d", i), vt[i].half, vt[i].lba, vt[i].fails,
                  vt[i].ack_dly, vt[i].done_dly, vt[i].bw, vt[i].wr, vt[i].fault);
        end
        m_lba = 32'd106; m_written = 32'd5; m_bw = 2'b11; m_fault = 1'b1;

        // HALT: fills ignored until ENA toggles, LBA stream continues
        chk("halt_busy", BUSY, 0);
        fill(1'b0);
        seen = 0;
        repeat (20) begin step(); if (WR_REQ) seen = 1; end
        chk("halt_no_req", seen, 0);
        ena_cycle();
        fill(1'b0);
        serve("post_halt", 1'b0, m_lba, 0, 1, 2, m_bw ^ 2'b01, m_written + 1, m_fault);
        model_sector(1'b0, 0);

        // OVERRUN: second rise on half 0 while it is still pending
        ena_cycle();
        chk("ovr_before", OVERRUN, 0);
        fill(1'b0);
        step();
        fill(1'b0);
        step();
        chk("ovr_set", OVERRUN, 1);
        serve("ovr", 1'b0, m_lba, 0, 0, 2, m_bw ^ 2'b01, m_written + 1, m_fault);
        model_sector(1'b0, 0);
        seen = 0;
        repeat (20) begin step(); if (WR_REQ) seen = 1; end
        chk("ovr_single_write", seen, 0);

        // randomized sessions against the model
        for (int s = 0; s < 2; s++) begin
            ena_cycle();
            h = 1'b0;
            for (int k = 0; k < 6; k++) begin
                r = $urandom_range(0, 9);
                f = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
                fill(h);
                repeat ($urandom_range(0, 2)) step();
                begin
                    logic [1:0] bw_n;
                    bw_n = m_bw; bw_n[h] = ~bw_n[h];
                    serve($sformatf("rnd%0d_%0d", s, k), h, m_lba, f,
                          $urandom_range(0, 3), $urandom_range(0, 4),
                          bw_n, m_written + ((f < 3) ? 1 : 0), m_fault | (f >= 3));
                end
                model_sector(h, f);
                h = ~h;
            end
            chk("rnd_halt_busy", BUSY, 0);
            fill(1'b0);
            seen = 0;
            repeat (10) begin step(); if (WR_REQ) seen = 1; end
            chk("rnd_halt_no_req", seen, 0);
        end

        // WAIT_DONE watchdog and asynchronous reset mid-transfer
        ena_cycle();
        fill(1'b0);
        step();
        chk("tmo_req", WR_REQ, 1);
        WR_ACK = 1'b1; step(); WR_ACK = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        n = 0;
        while (!WR_REQ && n < 200) begin step(); n++; end
        chk("tmo_rereq_cycle", n, 50);
        chk("tmo_rereq_lba", WR_LBA, m_lba);
        WR_ACK = 1'b1; step(); WR_ACK = 1'b0;
        repeat (5) step();
`else
        n = 0;
        seen = 0;
        repeat (10000) begin step(); if (WR_REQ) seen = 1; end
        chk("no_tmo_rereq", seen, 0);
        chk("no_tmo_busy", BUSY, 1);
`endif
        RST = 1'b0;
        #1;
        chk("arst_wr_lba", WR_LBA, 0);
        chk("arst_written", SECTORS_WRITTEN, 0);
        chk("arst_flags", {BUFWAITING, WR_REQ, WR_HALF, OVERRUN, FAULT, BUSY}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
